systolic_slice_receiver: RTL and testbench

//  Consumer side of the MtrxA/MtrxB slice stream. Accepts A and B slices (valid/ready/done) into per-matrix

---
 rtl/systolic_slice_receiver_pkg.sv | 17 +
 rtl/systolic_slice_receiver_if.sv | 40 ++++
 rtl/systolic_slice_receiver_pingpong_buf.sv | 90 +++++++++
 rtl/systolic_slice_receiver.sv | 128 ++++++++++++
 tb/tb_systolic_slice_receiver.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_slice_receiver_pkg.sv
// Shared sizing and read-FSM encoding for the slice receiver and its ping-pong buffers.
package systolic_slice_receiver_pkg;
    localparam int DATA_WIDTH = 64;
    localparam int SLICE_LEN  = 32;
    localparam int CNT_W      = 16;
    localparam int ADDR_W     = $clog2(SLICE_LEN);

    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(SLICE_LEN - 1);

    typedef logic [DATA_WIDTH-1:0] beat_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_LOAD   = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_e;
endpackage

// File: rtl/systolic_slice_receiver_if.sv
// Slice-stream inputs (A/B valid/ready/done) and the paired feed output toward the systolic array.
interface systolic_slice_receiver_if;
    import systolic_slice_receiver_pkg::*;

    logic               MtrxA_slice_valid;
    beat_t              MtrxA_slice_data;
    logic               MtrxA_slice_done;
    logic               MtrxA_slice_ready;
    logic               MtrxB_slice_valid;
    beat_t              MtrxB_slice_data;
    logic               MtrxB_slice_done;
    logic               MtrxB_slice_ready;
    logic               feed_valid;
    beat_t              feed_a_data;
    beat_t              feed_b_data;
    logic               feed_last;
    logic               feed_ready;
    logic [CNT_W-1:0]   slice_pair_cnt;
    logic               proto_err;

    modport master (
        output MtrxA_slice_valid, MtrxA_slice_data, MtrxA_slice_done,
        input  MtrxA_slice_ready,
        output MtrxB_slice_valid, MtrxB_slice_data, MtrxB_slice_done,
        input  MtrxB_slice_ready,
        input  feed_valid, feed_a_data, feed_b_data, feed_last,
        output feed_ready,
        input  slice_pair_cnt, proto_err
    );

    modport slave (
        input  MtrxA_slice_valid, MtrxA_slice_data, MtrxA_slice_done,
        output MtrxA_slice_ready,
        input  MtrxB_slice_valid, MtrxB_slice_data, MtrxB_slice_done,
        output MtrxB_slice_ready,
        output feed_valid, feed_a_data, feed_b_data, feed_last,
        input  feed_ready,
        output slice_pair_cnt, proto_err
    );
endinterface

// File: rtl/systolic_slice_receiver_pingpong_buf.sv
// Two-bank slice buffer for one matrix: fills banks alternately, flags full banks, checks the done window.
// Read port is registered and only updates on i_rd_en; writer stalls (o_ready low) while its target bank is full.
module slice_pingpong_buf
    import systolic_slice_receiver_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  beat_t               i_data,
    input  logic                i_done,
    output logic                o_ready,
    output logic [1:0]          o_full,
    input  logic                i_clr,
    input  logic                i_clr_bank,
    input  logic                i_rd_en,
    input  logic                i_rd_bank,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    output beat_t               o_rd_data,
    output logic                o_err
);
    beat_t              r_mem [2*SLICE_LEN];
    logic               r_wr_bank;
    logic [ADDR_W-1:0]  r_wr_cnt;
    logic [1:0]         r_full;
    logic [1:0]         r_win;
    logic               r_err;
    beat_t              r_rd_data;

    logic               w_accept;
    logic               w_complete;
    logic               w_done_ok;
    logic [1:0]         w_full_nxt;

    assign o_ready    = ~r_full[r_wr_bank];
    assign w_accept   = i_valid & o_ready;
    assign w_complete = w_accept & (r_wr_cnt == LAST_BEAT);
    // done is legal on the completing beat and the two cycles after it
    assign w_done_ok  = w_complete | (r_win != 2'd0);

    // clear and set always target different banks, so both can land in one cycle
    always_comb begin
        w_full_nxt = r_full;
        if (i_clr) begin
            w_full_nxt[i_clr_bank] = 1'b0;
        end
        if (w_complete) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_full    <= 2'b00;
            r_win     <= 2'd0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_accept) begin
                r_wr_cnt <= w_complete ? '0 : r_wr_cnt + 1'b1;
                if (w_complete) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_complete) begin
                r_win <= 2'd2;
            end else if (r_win != 2'd0) begin
                r_win <= r_win - 2'd1;
            end
            if (i_done && !w_done_ok) begin
                r_err <= 1'b1;
            end
            if (i_rd_en) begin
                r_rd_data <= r_mem[{i_rd_bank, i_rd_addr}];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mem[{r_wr_bank, r_wr_cnt}] <= i_data;
        end
    end

    assign o_full    = r_full;
    assign o_rd_data = r_rd_data;
    assign o_err     = r_err;
endmodule

// File: rtl/systolic_slice_receiver.sv
// Buffers A/B slices in ping-pong banks and replays each matched pair beat-aligned to the array feeder.
// feed_valid rises two clocks after the pair completes; feed outputs hold while feed_ready is low.
module systolic_slice_receiver
    import systolic_slice_receiver_pkg::*;
(
    input  logic                        s_clk,
    input  logic                        s_rst,
    systolic_slice_receiver_if.slave    bus
);
    rd_state_e          r_state;
    rd_state_e          w_state_nxt;
    logic               r_rd_bank;
    logic [ADDR_W-1:0]  r_rd_cnt;
    logic               r_feed_valid;
    logic               r_feed_last;
    logic [CNT_W-1:0]   r_pair_cnt;

    logic [1:0]         w_full_a;
    logic [1:0]         w_full_b;
    logic               w_err_a;
    logic               w_err_b;
    logic               w_hs;
    logic               w_last_hs;
    logic               w_rd_en;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic               w_pair_cur;
    logic               w_pair_oth;

    slice_pingpong_buf u_buf_a (
        .i_clk      (s_clk),
        .i_rst      (s_rst),
        .i_valid    (bus.MtrxA_slice_valid),
        .i_data     (bus.MtrxA_slice_data),
        .i_done     (bus.MtrxA_slice_done),
        .o_ready    (bus.MtrxA_slice_ready),
        .o_full     (w_full_a),
        .i_clr      (w_last_hs),
        .i_clr_bank (r_rd_bank),
        .i_rd_en    (w_rd_en),
        .i_rd_bank  (r_rd_bank),
        .i_rd_addr  (w_rd_addr),
        .o_rd_data  (bus.feed_a_data),
        .o_err      (w_err_a)
    );

    slice_pingpong_buf u_buf_b (
        .i_clk      (s_clk),
        .i_rst      (s_rst),
        .i_valid    (bus.MtrxB_slice_valid),
        .i_data     (bus.MtrxB_slice_data),
        .i_done     (bus.MtrxB_slice_done),
        .o_ready    (bus.MtrxB_slice_ready),
        .o_full     (w_full_b),
        .i_clr      (w_last_hs),
        .i_clr_bank (r_rd_bank),
        .i_rd_en    (w_rd_en),
        .i_rd_bank  (r_rd_bank),
        .i_rd_addr  (w_rd_addr),
        .o_rd_data  (bus.feed_b_data),
        .o_err      (w_err_b)
    );

    assign w_pair_cur = w_full_a[r_rd_bank]  & w_full_b[r_rd_bank];
    assign w_pair_oth = w_full_a[~r_rd_bank] & w_full_b[~r_rd_bank];
    assign w_hs       = r_feed_valid & bus.feed_ready;
    assign w_last_hs  = (r_state == RD_STREAM) & w_hs & (r_rd_cnt == LAST_BEAT);

    // Next beat is fetched on the handshake so it is presented the following cycle without a bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_rd_addr   = '0;
        case (r_state)
            RD_IDLE: begin
                if (w_pair_cur) begin
                    w_state_nxt = RD_LOAD;
                end
            end
            RD_LOAD: begin
                w_rd_en     = 1'b1;
                w_state_nxt = RD_STREAM;
            end
            RD_STREAM: begin
                if (w_hs) begin
                    if (r_rd_cnt == LAST_BEAT) begin
                        w_state_nxt = w_pair_oth ? RD_LOAD : RD_IDLE;
                    end else begin
                        w_rd_en   = 1'b1;
                        w_rd_addr = r_rd_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            r_state      <= RD_IDLE;
            r_rd_bank    <= 1'b0;
            r_rd_cnt     <= '0;
            r_feed_valid <= 1'b0;
            r_feed_last  <= 1'b0;
            r_pair_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == RD_LOAD) begin
                r_feed_valid <= 1'b1;
                r_feed_last  <= 1'b0;
                r_rd_cnt     <= '0;
            end else if (w_last_hs) begin
                r_feed_valid <= 1'b0;
                r_feed_last  <= 1'b0;
                r_rd_cnt     <= '0;
                r_rd_bank    <= ~r_rd_bank;
                r_pair_cnt   <= r_pair_cnt + 1'b1;
            end else if ((r_state == RD_STREAM) && w_hs) begin
                r_rd_cnt    <= w_rd_addr;
                r_feed_last <= (w_rd_addr == LAST_BEAT);
            end
        end
    end

    assign bus.feed_valid     = r_feed_valid;
    assign bus.feed_last      = r_feed_last;
    assign bus.slice_pair_cnt = r_pair_cnt;
    assign bus.proto_err      = w_err_a | w_err_b;
endmodule

// File: tb/tb_systolic_slice_receiver.sv
// Directed bench for systolic_slice_receiver: pairing, backpressure, latency, done window and reset.
module tb_systolic_slice_receiver;
    import systolic_slice_receiver_pkg::*;

    logic s_clk = 1'b0;
    logic s_rst = 1'b1;
    always #5 s_clk = ~s_clk;

    systolic_slice_receiver_if bus();

    systolic_slice_receiver dut (
        .s_clk (s_clk),
        .s_rst (s_rst),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic fr_hold   = 1'b0;
    logic fr_toggle = 1'b0;
    logic fr_q      = 1'b1;
    assign bus.feed_ready = fr_q;

    beat_t cap_a[$];
    beat_t cap_b[$];
    logic  cap_last[$];
    int    cap_cyc[$];
    logic  stall_d = 1'b0;
    beat_t hold_a  = '0;
    beat_t hold_b  = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    always @(posedge s_clk) cyc <= cyc + 1;

    always @(posedge s_clk) begin
        #1;
        if (fr_hold) fr_q <= 1'b0;
        else if (fr_toggle) fr_q <= ~fr_q;
        else fr_q <= 1'b1;
    end

    // Capture every feed handshake and verify the outputs held through each stall.
    always @(negedge s_clk) begin
        if (s_rst) begin
            stall_d <= 1'b0;
        end else begin
            if (stall_d) begin
                check("stall_valid", bus.feed_valid, 1);
                check("stall_a", bus.feed_a_data, hold_a);
                check("stall_b", bus.feed_b_data, hold_b);
            end
            if (bus.feed_valid && bus.feed_ready) begin
                cap_a.push_back(bus.feed_a_data);
                cap_b.push_back(bus.feed_b_data);
                cap_last.push_back(bus.feed_last);
                cap_cyc.push_back(cyc);
            end
            stall_d <= bus.feed_valid && !bus.feed_ready;
            hold_a  <= bus.feed_a_data;
            hold_b  <= bus.feed_b_data;
        end
    end

    task automatic drive(input bit is_b, input logic v, input beat_t d, input logic dn);
        if (is_b) begin
            bus.MtrxB_slice_valid = v;
            bus.MtrxB_slice_data  = d;
            bus.MtrxB_slice_done  = dn;
        end else begin
            bus.MtrxA_slice_valid = v;
            bus.MtrxA_slice_data  = d;
            bus.MtrxA_slice_done  = dn;
        end
    endtask

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    // done_k: beat index carrying done, SLICE_LEN = one cycle after the last beat, -1 = never.
    task automatic send_slice(input bit is_b, input int base, input int done_k);
        int   guard;
        logic rdy;
        for (int k = 0; k < SLICE_LEN; k++) begin
            guard = 0;
            drive(is_b, 1'b1, beat_t'(base + k), k == done_k);
            forever begin
                rdy = is_b ? bus.MtrxB_slice_ready : bus.MtrxA_slice_ready;
                tick();
                if (rdy) break;
                guard++;
                if (guard > 3000) begin
                    check(is_b ? "b_ready_timeout" : "a_ready_timeout", 0, 1);
                    drive(is_b, 1'b0, '0, 1'b0);
                    return;
                end
            end
        end
        drive(is_b, 1'b0, '0, done_k == SLICE_LEN);
        if (done_k == SLICE_LEN) begin
            tick();
            drive(is_b, 1'b0, '0, 1'b0);
        end
    endtask

    task automatic send_pair(input int a0, input int b0);
        fork
            send_slice(1'b0, a0, -1);
            send_slice(1'b1, b0, -1);
        join
    endtask

    task automatic clear_cap();
        cap_a.delete();
        cap_b.delete();
        cap_last.delete();
        cap_cyc.delete();
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();
        tick();
        s_rst = 1'b0;
        clear_cap();
    endtask

    task automatic wait_cnt(input int n);
        int g;
        g = 0;
        while (bus.slice_pair_cnt != CNT_W'(n) && g < 3000) begin
            tick();
            g++;
        end
        check("pair_cnt", bus.slice_pair_cnt, n);
        tick();
        tick();
    endtask

    task automatic check_pair(input int a0, input int b0);
        beat_t ga, gb;
        logic  gl;
        check("beats_avail", cap_a.size() >= SLICE_LEN, 1);
        if (cap_a.size() < SLICE_LEN) return;
        for (int k = 0; k < SLICE_LEN; k++) begin
            ga = cap_a.pop_front();
            gb = cap_b.pop_front();
            gl = cap_last.pop_front();
            void'(cap_cyc.pop_front());
            check("feed_a", ga, a0 + k);
            check("feed_b", gb, b0 + k);
            check("feed_last", gl, k == SLICE_LEN - 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        do_reset();
        // reset state, sampled while reset is still asserted
        s_rst = 1'b1;
        tick();
        check("rst_feed_valid", bus.feed_valid, 0);
        check("rst_feed_last", bus.feed_last, 0);
        check("rst_feed_a", bus.feed_a_data, 0);
        check("rst_feed_b", bus.feed_b_data, 0);
        check("rst_pair_cnt", bus.slice_pair_cnt, 0);
        check("rst_proto_err", bus.proto_err, 0);
        s_rst = 1'b0;
        check("rst_ready_a", bus.MtrxA_slice_ready, 1);
        check("rst_ready_b", bus.MtrxB_slice_ready, 1);

        // 1: single pair, latency from last B beat to feed_valid
        send_pair(0, 100);
        check("lat_edge0", bus.feed_valid, 0);
        tick();
        check("lat_edge1", bus.feed_valid, 0);
        tick();
        check("lat_edge2", bus.feed_valid, 1);
        wait_cnt(1);
        check_pair(0, 100);
        check("t1_no_extra", cap_a.size(), 0);

        // 2: A runs two slices ahead and is then stalled
        do_reset();
        send_slice(1'b0, 200, -1);
        send_slice(1'b0, 300, -1);
        check("t2_ready_a_low", bus.MtrxA_slice_ready, 0);
        for (int i = 0; i < 5; i++) tick();
        check("t2_no_feed", bus.feed_valid, 0);
        check("t2_no_beats", cap_a.size(), 0);
        fork
            send_slice(1'b0, 400, -1);
            begin
                send_slice(1'b1, 500, -1);
                send_slice(1'b1, 600, -1);
            end
        join
        wait_cnt(2);
        for (int i = 0; i < 5; i++) tick();
        check_pair(200, 500);
        check_pair(300, 600);
        check("t2_no_extra", cap_a.size(), 0);

        // 3: feed_ready toggling every cycle
        do_reset();
        fr_toggle = 1'b1;
        send_pair(700, 800);
        wait_cnt(1);
        fr_toggle = 1'b0;
        check_pair(700, 800);
        check("t3_no_extra", cap_a.size(), 0);

        // 4: both banks full, back-to-back pairs
        do_reset();
        fr_hold = 1'b1;
        fork
            begin
                send_slice(1'b0, 900, -1);
                send_slice(1'b0, 1000, -1);
            end
            begin
                send_slice(1'b1, 1100, -1);
                send_slice(1'b1, 1200, -1);
            end
        join
        fr_hold = 1'b0;
        wait_cnt(2);
        check("t4_beats", cap_cyc.size(), 2 * SLICE_LEN);
        if (cap_cyc.size() >= 2 * SLICE_LEN) begin
            check("t4_no_bubble", cap_cyc[SLICE_LEN + 1] - cap_cyc[SLICE_LEN], 1);
            check("t4_load_gap", cap_cyc[SLICE_LEN] - cap_cyc[SLICE_LEN - 1], 2);
        end
        check_pair(900, 1100);
        check_pair(1000, 1200);

        // 5: done window
        do_reset();
        fork
            send_slice(1'b0, 0, SLICE_LEN);
            send_slice(1'b1, 100, -1);
        join
        wait_cnt(1);
        check("t5_done_in_window", bus.proto_err, 0);
        check_pair(0, 100);
        send_slice(1'b0, 2000, 10);
        check("t5_done_early", bus.proto_err, 1);
        for (int i = 0; i < 5; i++) tick();
        check("t5_err_sticky", bus.proto_err, 1);

        // 6: reset in the middle of streaming
        do_reset();
        send_pair(3000, 3100);
        g = 0;
        while (cap_a.size() < 15 && g < 500) begin
            tick();
            g++;
        end
        check("t6_reached_beat15", cap_a.size() >= 15, 1);
        s_rst = 1'b1;
        tick();
        check("t6_feed_valid", bus.feed_valid, 0);
        check("t6_ready_a", bus.MtrxA_slice_ready, 1);
        check("t6_ready_b", bus.MtrxB_slice_ready, 1);
        check("t6_pair_cnt", bus.slice_pair_cnt, 0);
        s_rst = 1'b0;
        clear_cap();
        for (int i = 0; i < 6; i++) tick();
        check("t6_quiet", cap_a.size(), 0);
        send_pair(3200, 3300);
        wait_cnt(1);
        check_pair(3200, 3300);
        check("t6_no_extra", cap_a.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
